// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush bus between the pipeline stages and pipe_stall_ctrl.
// master = pipeline side (raises requests), slave = the controller.
interface pipe_stall_ctrl_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        clr_timeout_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout_o;
    logic [31:0] stall_cycles_o;

    modport master (
        output stallreq_from_id,
        output stallreq_from_ex,
        output stallreq_from_mem,
        output excepttype_i,
        output cp0_epc_i,
        output clr_timeout_i,
        input  stall,
        input  flush,
        input  new_pc,
        input  stall_timeout_o,
        input  stall_cycles_o
    );

    modport slave (
        input  stallreq_from_id,
        input  stallreq_from_ex,
        input  stallreq_from_mem,
        input  excepttype_i,
        input  cp0_epc_i,
        input  clr_timeout_i,
        output stall,
        output flush,
        output new_pc,
        output stall_timeout_o,
        output stall_cycles_o
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer with stall watchdog; optional perf counter via PIPE_STALL_PERF_EN.
// Latency: stall/flush/new_pc combinational; watchdog flag and perf counter update on the next edge.
// Backpressure: none of its own; the stall bus it drives is the pipeline's backpressure.
module pipe_stall_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
    parameter int unsigned FLUSH_HOLD    = 1,
    parameter int unsigned STALL_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave bus
);

    localparam logic [31:0] ERET_CODE   = 32'h0000000e;
    localparam logic [3:0]  HOLD_INIT   = 4'(FLUSH_HOLD - 1);
    localparam logic [7:0]  TIMEOUT_CNT = 8'(STALL_TIMEOUT);
    localparam logic [5:0]  STALL_NONE  = 6'b000000;
    localparam logic [5:0]  STALL_ID    = 6'b000111;
    localparam logic [5:0]  STALL_EX    = 6'b001111;
    localparam logic [5:0]  STALL_MEM   = 6'b011111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  hold_q;
    logic [3:0]  hold_d;
    logic [7:0]  stall_cnt_q;
    logic [7:0]  stall_cnt_d;
    logic        timeout_q;
    logic        timeout_d;
    logic [5:0]  stall_d;
    logic        flush_d;
    logic [31:0] new_pc_d;
    logic        stall_any;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            hold_q      <= 4'd0;
            stall_cnt_q <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // FLUSH masks both exceptions and stall requests while the pipe refills.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        stall_d  = STALL_NONE;
        flush_d  = 1'b0;
        new_pc_d = 32'h0;
        if (state_q == FLUSH) begin
            if (hold_q == 4'd0) begin
                state_d = RUN;
            end else begin
                hold_d = hold_q - 4'd1;
            end
        end else if (bus.excepttype_i != 32'h0) begin
            flush_d  = 1'b1;
            new_pc_d = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
            state_d  = FLUSH;
            hold_d   = HOLD_INIT;
        end else begin
            if (bus.stallreq_from_mem) begin
                stall_d = STALL_MEM;
            end else if (bus.stallreq_from_ex) begin
                stall_d = STALL_EX;
            end else if (bus.stallreq_from_id) begin
                stall_d = STALL_ID;
            end
            state_d = (stall_d != STALL_NONE) ? STALL : RUN;
        end
    end

    assign bus.stall  = rst ? stall_d  : STALL_NONE;
    assign bus.flush  = rst & flush_d;
    assign bus.new_pc = rst ? new_pc_d : 32'h0;
    assign stall_any  = |bus.stall;

    // Watchdog: set wins over a coincident clear.
    always_comb begin
        stall_cnt_d = 8'd0;
        if (stall_any) begin
            stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
        end
        if (stall_any && (stall_cnt_d == TIMEOUT_CNT)) begin
            timeout_d = 1'b1;
        end else if (bus.clr_timeout_i) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    assign bus.stall_timeout_o = timeout_q;

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= 32'h0;
        end else if (stall_any && (perf_q != 32'hFFFFFFFF)) begin
            perf_q <= perf_q + 32'h1;
        end
    end

    assign bus.stall_cycles_o = perf_q;
`else
    assign bus.stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed + random bench for pipe_stall_ctrl against a cycle-level reference model.
module tb_pipe_stall_ctrl;
    localparam int          TO   = 4;
    localparam int          HOLD = 1;
    localparam logic [31:0] VEC  = 32'h00000020;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipe_stall_ctrl_if bus();

    pipe_stall_ctrl #(
        .EXC_VECTOR    (VEC),
        .FLUSH_HOLD    (HOLD),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: remaining FLUSH cycles, consecutive stalls, flag, perf count
    int              m_flush_left;
    int              m_consec;
    bit              m_to;
    longint unsigned m_perf;
    logic [5:0]      e_stall;
    logic            e_flush;
    logic [31:0]     e_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_consec     = 0;
        m_to         = 1'b0;
        m_perf       = 0;
    endtask

    function automatic logic [31:0] exp_perf();
`ifdef PIPE_STALL_PERF_EN
        return m_perf[31:0];
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_outputs();
        e_stall = 6'b0;
        e_flush = 1'b0;
        e_pc    = 32'h0;
        if (m_flush_left == 0) begin
            if (bus.excepttype_i != 0) begin
                e_flush = 1'b1;
                e_pc    = (bus.excepttype_i == 32'he) ? bus.cp0_epc_i : VEC;
            end else if (bus.stallreq_from_mem) e_stall = 6'b011111;
            else if (bus.stallreq_from_ex)      e_stall = 6'b001111;
            else if (bus.stallreq_from_id)      e_stall = 6'b000111;
        end
    endtask

    task automatic model_update();
        bit stalled;
        stalled = (e_stall != 0);
        if (m_flush_left > 0) m_flush_left--;
        else if (bus.excepttype_i != 0) m_flush_left = HOLD;
        m_consec = stalled ? ((m_consec < 255) ? m_consec + 1 : 255) : 0;
        if (stalled && m_consec == TO) m_to = 1'b1;
        else if (bus.clr_timeout_i) m_to = 1'b0;
        if (stalled && m_perf < 64'hFFFFFFFF) m_perf++;
    endtask

    task automatic step(input string tag, input bit id, input bit ex, input bit mem,
                        input logic [31:0] exc, input logic [31:0] epc, input bit clr);
        bus.stallreq_from_id  = id;
        bus.stallreq_from_ex  = ex;
        bus.stallreq_from_mem = mem;
        bus.excepttype_i      = exc;
        bus.cp0_epc_i         = epc;
        bus.clr_timeout_i     = clr;
        #1;
        model_outputs();
        chk({tag, "_stall"}, 32'(bus.stall), 32'(e_stall));
        chk({tag, "_flush"}, 32'(bus.flush), 32'(e_flush));
        chk({tag, "_pc"}, bus.new_pc, e_pc);
        @(posedge clk);
        model_update();
        #1;
        chk({tag, "_timeout"}, 32'(bus.stall_timeout_o), 32'(m_to));
        chk({tag, "_perf"}, bus.stall_cycles_o, exp_perf());
    endtask

    logic [31:0] codes [7];

    initial begin
        codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h40};
        model_reset();
        // Requests and an exception present during reset must not reach the outputs
        bus.stallreq_from_id  = 1'b0;
        bus.stallreq_from_ex  = 1'b0;
        bus.stallreq_from_mem = 1'b1;
        bus.excepttype_i      = 32'h8;
        bus.cp0_epc_i         = 32'h0;
        bus.clr_timeout_i     = 1'b0;
        #2;
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_pc", bus.new_pc, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_timeout", 32'(bus.stall_timeout_o), 32'h0);
        chk("rst_perf", bus.stall_cycles_o, 32'h0);
        rst = 1'b1;

        step("id1", 1, 0, 0, 0, 0, 0);
        step("id_off", 0, 0, 0, 0, 0, 0);
        step("all3", 1, 1, 1, 0, 0, 0);
        step("ex_id", 1, 1, 0, 0, 0, 0);
        step("id_only", 1, 0, 0, 0, 0, 0);
        step("idle", 0, 0, 0, 0, 0, 0);
        step("exc8", 0, 1, 0, 32'h8, 0, 0);
        step("exc8_flush", 0, 1, 0, 32'h8, 0, 0);
        step("exc8_again", 0, 1, 0, 32'h8, 0, 0);
        step("post_exc", 0, 0, 0, 0, 0, 0);
        step("eret", 0, 0, 0, 32'he, 32'h1234, 0);
        step("post_eret", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) step("wd_mem", 0, 0, 1, 0, 0, 0);
        chk("wd_set", 32'(bus.stall_timeout_o), 32'h1);
        step("wd_drop", 0, 0, 0, 0, 0, 0);
        chk("wd_sticky", 32'(bus.stall_timeout_o), 32'h1);
        step("wd_clr", 0, 0, 0, 0, 0, 1);
        chk("wd_cleared", 32'(bus.stall_timeout_o), 32'h0);

        // Fresh perf count, then an asynchronous reset in the middle of a stall
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 7; i++) step("perf", 0, 0, 1, 0, 0, 0);
`ifdef PIPE_STALL_PERF_EN
        chk("perf7", bus.stall_cycles_o, 32'd7);
`else
        chk("perf7", bus.stall_cycles_o, 32'd0);
`endif
        #2;
        rst = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.stall), 32'h0);
        chk("arst_perf", bus.stall_cycles_o, 32'h0);
        chk("arst_timeout", 32'(bus.stall_timeout_o), 32'h0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_run_stall", 32'(bus.stall), 32'(6'b011111));

        // Asynchronous reset during FLUSH returns straight to RUN
        step("fl_enter", 0, 0, 0, 32'h1, 0, 0);
        chk("fl_masked", 32'(bus.flush), 32'h0);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("fl_arst_flush", 32'(bus.flush), 32'h1);
        chk("fl_arst_pc", bus.new_pc, VEC);

        for (int i = 0; i < 500; i++) begin
            logic [31:0] exc;
            exc = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 6)] : 32'h0;
            step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), exc, $urandom(),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Merges stall requests from ID, EX and MEM into the 6-bit stall bus consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. Bit 0 = PC, bits 1..5 = IF, ID, EX, MEM, WB.
- Accepts exception types from MEM, raises flush and selects the restart PC.
- Sequences a post-flush refill window and runs a stall watchdog.

Parameters:
- EXC_VECTOR, 32'h00000020, restart PC for all non-ERET exceptions.
- FLUSH_HOLD, 1, cycles after a flush during which exceptions are ignored and stall is forced to 0; legal range 1..15.
- STALL_TIMEOUT, 200, consecutive stalled cycles before the watchdog trips; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset. Port named rst as elsewhere in the codebase, but polarity is low.
- stallreq_from_id  in  1  ID needs a bubble (load-use).
- stallreq_from_ex  in  1  EX multi-cycle op busy (div/madd).
- stallreq_from_mem  in  1  MEM bus wait.
- excepttype_i  in  32  exception code from MEM; 0 = none.
- cp0_epc_i  in  32  EPC value, used for ERET.
- clr_timeout_i  in  1  clears the sticky watchdog flag.
- stall  out  6  stall bus; 1 = Stop.
- flush  out  1  flush all pipeline registers.
- new_pc  out  32  restart PC, valid while flush=1.
- stall_timeout_o  out  1  sticky watchdog flag.
- stall_cycles_o  out  32  performance counter (see Optional Feature).

Behaviour:
- States: RUN, STALL, FLUSH. Reset state is RUN.
- Reset values: hold counter 0, consecutive-stall counter 0, stall_timeout_o 0, stall_cycles_o 0.
- Reset is asynchronous. Asserting rst at any point, including mid-STALL or mid-FLUSH, clears all state immediately.
- stall, flush and new_pc are combinational from the current state and the inputs. All three are 0 while rst=0.
- Exception accepted: excepttype_i != 0 and state != FLUSH.
  - Same cycle: flush=1, stall=6'b000000.
  - new_pc = cp0_epc_i when excepttype_i == 32'h0000000e (ERET), else EXC_VECTOR.
  - Codes 32'h1, 8, a, c, d all map to EXC_VECTOR. Any other nonzero code also maps to EXC_VECTOR.
  - Next state FLUSH; hold counter loaded with FLUSH_HOLD-1.
- FLUSH state:
  - flush=0, stall=0, excepttype_i ignored, stall requests ignored.
  - Hold counter decrements each cycle. When it reads 0, next state is RUN.
  - A FLUSH_HOLD=1 window lasts exactly one cycle.
- No exception accepted (RUN or STALL): stall is encoded by priority.
  - stallreq_from_mem → 6'b011111.
  - else stallreq_from_ex → 6'b001111.
  - else stallreq_from_id → 6'b000111.
  - else 6'b000000.
  - flush=0; new_pc=0.
  - Next state is STALL if stall != 0, else RUN.
- Simultaneous exception and stall request: the exception wins; stall=0.
- Watchdog:
  - The consecutive-stall counter is 8 bits. It increments on each clock edge where stall != 0, saturating at 255, and clears on any edge where stall == 0.
  - When the counter value after update equals STALL_TIMEOUT, stall_timeout_o is set on that edge. STALL_TIMEOUT consecutive stalled cycles therefore produce the flag at the following edge.
  - The flag is sticky. It is cleared only by reset or by clr_timeout_i=1 sampled on an edge.
  - If set and clear coincide, set wins.
- The watchdog has no effect on stall or flush; it is report-only.

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- Defined: stall_cycles_o increments by 1 on every edge where stall != 0, saturating at 32'hFFFFFFFF. Reset to 0; it is not cleared by flush.
- Not defined: stall_cycles_o is tied to 32'h0 and no counter flops are instantiated. The port is present in both builds.

Test Plan:
- Reset, then stallreq_from_id=1 for 1 cycle → stall=6'b000111 that cycle, then 6'b000000; flush=0 throughout.
- Drive all three requests at once, then drop MEM, then drop EX → stall goes 6'b011111, then 6'b001111, then 6'b000111.
- excepttype_i=32'h8 together with stallreq_from_ex=1 → in the same cycle flush=1, stall=0, new_pc=32'h20. The next cycle (FLUSH) has flush=0 even if excepttype_i is still 32'h8. Flush re-asserts on the following cycle if the code is still present.
- excepttype_i=32'he, cp0_epc_i=32'h0000_1234 → flush=1, new_pc=32'h1234.
- With STALL_TIMEOUT=4, hold stallreq_from_mem for 4 cycles → stall_timeout_o=1 after the 4th edge and stays 1 after the request drops. Pulse clr_timeout_i → flag returns to 0.
- With PIPE_STALL_PERF_EN defined: 7 stalled cycles → stall_cycles_o=7. Pull rst low mid-stall → stall_cycles_o=0, stall=0 and state RUN immediately, without waiting for a clock edge.
